// File: rtl/serial_ks_subtractor.sv
// Multi-cycle subtractor: a - b - bin, one SLICE-bit Kogge-Stone slice per cycle,
// with a borrow chain carried between slices and a valid/ready handshake on both sides.
module serial_ks_subtractor #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              carry;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [SLICE-1:0]  a_s;
   logic [SLICE-1:0]  b_s;
   logic [SLICE-1:0]  sum_s;
   logic              cout_s;

   // Kogge-Stone adder; carry-in folded into bit 0's generate so the prefix tree yields every carry.
   function automatic logic [SLICE:0] ks_add(input logic [SLICE-1:0] x,
                                             input logic [SLICE-1:0] y,
                                             input logic             cin);
      logic [SLICE-1:0] p;
      logic [SLICE-1:0] gp;
      logic [SLICE-1:0] pp;
      logic [SLICE-1:0] gn;
      logic [SLICE-1:0] pn;
      logic [SLICE:0]   c;
      p     = x ^ y;
      gp    = x & y;
      gp[0] = gp[0] | (p[0] & cin);
      pp    = p;
      for (int d = 1; d < SLICE; d = d * 2) begin
         gn = gp;
         pn = pp;
         for (int i = d; i < SLICE; i++) begin
            gn[i] = gp[i] | (pp[i] & gp[i-d]);
            pn[i] = pp[i] & pp[i-d];
         end
         gp = gn;
         pp = pn;
      end
      c = {gp, cin};
      return {c[SLICE], p ^ c[SLICE-1:0]};
   endfunction

   always_comb begin
      a_s             = a_r[cnt*SLICE +: SLICE];
      b_s             = b_r[cnt*SLICE +: SLICE];
      {cout_s, sum_s} = ks_add(a_s, ~b_s, carry);
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_r <= a;
         b_r <= b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         carry    <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= ~bin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               diff[cnt*SLICE +: SLICE] <= sum_s;
               carry <= cout_s;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(NSLICE - 1)) begin
                  // borrow is the inverted carry of a + ~b + ~bin
                  bout     <= ~cout_s;
                  overflow <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum_s[SLICE-1] != a_r[WIDTH-1]);
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_ks_subtractor.sv
// Directed and random checks of serial_ks_subtractor against an arithmetic model of a - b - bin.
module tb_serial_ks_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] diff;
   logic        bout;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   serial_ks_subtractor #(.WIDTH(64), .SLICE(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer arithmetic in 66 bits, then judge borrow and signed range.
   function automatic logic [65:0] ref_sub(input logic [63:0] x, input logic [63:0] y, input logic c);
      logic [64:0]        u;
      logic signed [65:0] s;
      logic               ovf;
      u   = {1'b0, x} - {1'b0, y} - {64'd0, c};
      s   = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, c});
      ovf = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
      return {ovf, u[64], u[63:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      bin      = 1'($urandom);
      in_valid = 1'($urandom);
   endtask

   // Called 1 time unit after an edge with the DUT idle.
   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tbin,
                         input int stall, input logic [65:0] exp);
      int lat;
      check("idle_in_ready", 64'(in_ready), 64'd1);
      a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
      step();
      lat = 0;
      while (!out_valid && lat < 20) begin
         scramble();
         out_ready = 1'($urandom);
         step();
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      out_ready = 1'b0;
      check("diff", diff, exp[63:0]);
      check("bout", 64'(bout), 64'(exp[64]));
      check("overflow", 64'(overflow), 64'(exp[65]));
      for (int i = 0; i < stall; i++) begin
         scramble();
         step();
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_ready", 64'(in_ready), 64'd0);
         check("stall_diff", diff, exp[63:0]);
      end
      scramble();
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("handoff_valid", 64'(out_valid), 64'd0);
      check("handoff_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      step(); step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", diff, 64'd0);
      check("rst_bout", 64'(bout), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      step();
      check("rst_in_ready", 64'(in_ready), 64'd1);

      run_op(64'h5, 64'h3, 1'b0, 0, {1'b0, 1'b0, 64'h2});
      run_op(64'h0, 64'h1, 1'b0, 0, {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
      run_op(64'h5, 64'h3, 1'b1, 0, {1'b0, 1'b0, 64'h1});
      run_op(64'h0000_0000_0001_0000, 64'h1, 1'b0, 0, {1'b0, 1'b0, 64'h0000_0000_0000_FFFF});
      run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, {1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF});
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             0, {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
      run_op(64'h1234, 64'h1234, 1'b0, 0, {1'b0, 1'b0, 64'h0});
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             0, {1'b1, 1'b1, 64'h8000_0000_0000_0000});
      run_op(64'h9, 64'h4, 1'b0, 3, {1'b0, 1'b0, 64'h5});

      // Reset after two slices aborts the operation.
      a = 64'h1_0000_0000; b = 64'h1; bin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_diff", diff, 64'd0);
      check("abort_bout", 64'(bout), 64'd0);
      check("abort_overflow", 64'(overflow), 64'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
         end
         check("abort_no_valid", 64'(seen), 64'd0);
      end
      run_op(64'h10, 64'h1, 1'b0, 0, {1'b0, 1'b0, 64'hF});

      // Reset coincident with in_valid must not accept.
      rst_n = 1'b0; in_valid = 1'b1; a = 64'h77; b = 64'h1;
      step();
      rst_n = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("rst_accept_valid", 64'(out_valid), 64'd0);
      check("rst_accept_ready", 64'(in_ready), 64'd1);

      for (int n = 0; n < 10000; n++) begin
         logic [63:0] ra;
         logic [63:0] rb;
         logic        rc;
         int          st;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: ra = '0;
            2: rb = '1;
            default: ;
         endcase
         rc = 1'($urandom);
         st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op(ra, rb, rc, st, ref_sub(ra, rb, rc));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
